// File: rtl/cam_frame_writer_pkg.sv
// cam_frame_writer_pkg: shared state encoding, default geometry and buffer occupancy helper.
package cam_frame_writer_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_STREAM} state_t;
  localparam int FRAME_W_DEF = 640;
  localparam int FRAME_H_DEF = 480;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 19;
  // entries held in buffer plus in flight once this cycle's accept has left
  function automatic logic [2:0] occupancy(input logic [1:0] count, input logic inflight, input logic pop);
    return 3'(count) + 3'(inflight) - 3'(pop);
  endfunction
endpackage

// File: rtl/cam_frame_writer_pix_skid_buf.sv
// pix_skid_buf: 2-entry pixel buffer absorbing the FIFO read latency under write backpressure.
module pix_skid_buf #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);
  logic [DATA_WIDTH-1:0] d1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= 2'd0;
      head <= '0;
      d1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      if (pop) head <= (count == 2'd2) ? d1 : din;
      else if (push && count == 2'd0) head <= din;
      if (push && (count - 2'(pop)) == 2'd1) d1 <= din;
    end
endmodule

// File: rtl/cam_frame_writer.sv
// cam_frame_writer: drains the camera pixel FIFO into linear, double-banked framebuffer writes.
module cam_frame_writer
  import cam_frame_writer_pkg::*;
#(
  parameter int FRAME_W    = FRAME_W_DEF,
  parameter int FRAME_H    = FRAME_H_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_frame_start,
  input  logic [DATA_WIDTH-1:0] i_obuf_data,
  input  logic                  i_obuf_empty,
  output logic                  o_obuf_rd,
  output logic                  o_mem_wr,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_bank,
  input  logic                  i_mem_ready,
  output logic                  o_frame_done,
  output logic                  o_frame_err,
  output logic                  o_busy
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_W * FRAME_H - 1);
  state_t state;
  logic inflight, accept, last, flush;
  logic [1:0] count;
  assign o_mem_wr = count != 2'd0;
  assign accept = o_mem_wr && i_mem_ready;
  assign last = accept && o_mem_addr == LAST;
  // anything buffered outside an active frame, or across a frame boundary, is stale
  assign flush = !i_enable || state != S_STREAM || i_frame_start || last;
  assign o_obuf_rd = i_enable && !i_obuf_empty &&
                     (state == S_SYNC || (state == S_STREAM && occupancy(count, inflight, accept) < 3'd2));
  assign o_busy = state == S_STREAM;
  pix_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk(i_clk),
    .rst(i_rst),
    .push(inflight),
    .pop(accept),
    .flush(flush),
    .din(i_obuf_data),
    .count(count),
    .head(o_mem_wdata)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= S_IDLE;
      inflight <= 1'b0;
      o_mem_addr <= '0;
      o_mem_bank <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      inflight <= o_obuf_rd && state == S_STREAM && !flush;
      o_frame_done <= i_enable && last;
      o_frame_err <= i_enable && state == S_STREAM && i_frame_start && o_mem_addr != '0 && !last;
      if (i_enable && last) o_mem_bank <= !o_mem_bank;
      if (!i_enable) begin
        state <= S_IDLE;
        o_mem_addr <= '0;
      end else if (state == S_IDLE) begin
        state <= S_SYNC;
      end else if (i_frame_start) begin
        state <= S_STREAM;
        o_mem_addr <= '0;
      end else if (last) begin
        state <= S_SYNC;
        o_mem_addr <= '0;
      end else if (accept) begin
        o_mem_addr <= o_mem_addr + 1'b1;
      end
    end
endmodule

// File: tb/tb_cam_frame_writer.sv
// tb_cam_frame_writer: randomized frame streams on a 4x2 frame against a pixel-order scoreboard.
module tb_cam_frame_writer;
  localparam int FW = 4;
  localparam int FH = 2;
  localparam logic [2:0] LAST = 3'(FW * FH - 1);
  typedef struct packed {logic [2:0] addr; logic [15:0] data; logic bank;} exp_t;
  logic clk = 1'b0;
  logic i_rst, i_enable, i_frame_start, i_obuf_empty, i_mem_ready = 1'b0;
  logic [15:0] i_obuf_data = '0;
  logic o_obuf_rd, o_mem_wr, o_mem_bank, o_frame_done, o_frame_err, o_busy;
  logic [2:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  int checks = 0, errors = 0;
  logic [15:0] mem [0:1023];
  int wr_ptr = 0, rd_ptr = 0, cyc = 0, occ = 0, pcnt = 0;
  int rdy_mode;
  bit sb_en, stab_en, err_chk, nowr, exp_bank;
  bit rd_n = 0, stall_p = 0, done_due = 0;
  logic [2:0] addr_p;
  logic [15:0] data_p;
  exp_t exp_q[$];
  int acc_log[$];
  cam_frame_writer #(.FRAME_W(FW), .FRAME_H(FH), .DATA_WIDTH(16), .ADDR_W(3)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_frame_start(i_frame_start),
    .i_obuf_data(i_obuf_data), .i_obuf_empty(i_obuf_empty), .o_obuf_rd(o_obuf_rd),
    .o_mem_wr(o_mem_wr), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_bank(o_mem_bank), .i_mem_ready(i_mem_ready), .o_frame_done(o_frame_done),
    .o_frame_err(o_frame_err), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  assign i_obuf_empty = rd_ptr == wr_ptr;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, expv, $time);
    end
  endtask
  // FIFO model: read data appears one cycle after the read enable
  always @(posedge clk)
    if (rd_n) begin
      i_obuf_data <= mem[rd_ptr % 1024];
      rd_ptr <= rd_ptr + 1;
    end
  always @(posedge clk) begin
    #1;
    pcnt <= pcnt + 1;
    i_mem_ready <= rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) :
                   rdy_mode == 2 ? (pcnt % 4 == 0 || pcnt % 4 == 3) : 1'b0;
  end
  always @(negedge clk) begin
    int occ_new;
    exp_t e;
    bit acc;
    acc = o_mem_wr && i_mem_ready;
    cyc <= cyc + 1;
    rd_n <= o_obuf_rd;
    if (o_obuf_rd) chk("rd_empty", i_obuf_empty, 0);
    occ_new = (!o_busy || i_frame_start || (acc && o_mem_addr == LAST)) ? 0 : occ + int'(o_obuf_rd) - int'(acc);
    occ <= occ_new;
    if (stab_en) chk("occ", occ_new <= 2, 1);
    if (sb_en) begin
      chk("done", o_frame_done, done_due);
      if (err_chk) chk("err", o_frame_err, 0);
      if (nowr) chk("no_wr", o_mem_wr, 0);
      if (stall_p) begin
        chk("stall_wr", o_mem_wr, 1);
        chk("stall_addr", o_mem_addr, addr_p);
        chk("stall_data", o_mem_wdata, data_p);
      end
    end
    if (sb_en && acc) begin
      if (exp_q.size() == 0) begin
        chk("extra_wr", exp_q.size(), 1);
        done_due <= 0;
      end else begin
        e = exp_q.pop_front();
        chk("addr", o_mem_addr, e.addr);
        chk("data", o_mem_wdata, e.data);
        chk("bank", o_mem_bank, e.bank);
        done_due <= e.addr == LAST;
        acc_log.push_back(cyc);
      end
    end else done_due <= 0;
    stall_p <= sb_en && stab_en && o_mem_wr && !i_mem_ready && !i_frame_start && i_enable;
    addr_p <= o_mem_addr;
    data_p <= o_mem_wdata;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push_px(input logic [15:0] d, input bit expect_it, input logic [2:0] a);
    mem[wr_ptr % 1024] = d;
    wr_ptr++;
    if (expect_it) exp_q.push_back('{a, d, exp_bank});
  endtask
  task automatic pulse_sof();
    i_frame_start = 1;
    step();
    i_frame_start = 0;
  endtask
  task automatic drain();
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) step();
    chk("drain", exp_q.size(), 0);
    step();
    step();
  endtask
  task automatic frame(input bit sof, input int gap);
    if (sof) pulse_sof();
    for (int i = 0; i < FW * FH; i++) begin
      push_px(16'($urandom), 1, 3'(i));
      step();
      repeat ($urandom_range(0, gap)) step();
    end
    drain();
    exp_bank = !exp_bank;
    chk("frame_bank", o_mem_bank, exp_bank);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_wr"}, o_mem_wr, 0);
    chk({tag, "_rd"}, o_obuf_rd, 0);
    chk({tag, "_addr"}, o_mem_addr, 0);
    chk({tag, "_wdata"}, o_mem_wdata, 0);
    chk({tag, "_bank"}, o_mem_bank, 0);
    chk({tag, "_done"}, o_frame_done, 0);
    chk({tag, "_err"}, o_frame_err, 0);
    chk({tag, "_busy"}, o_busy, 0);
  endtask
  initial begin
    int n, rd_before;
    i_rst = 1; i_enable = 0; i_frame_start = 0; rdy_mode = 0;
    sb_en = 0; stab_en = 0; err_chk = 0; nowr = 0; exp_bank = 0;
    repeat (3) step();
    chk_zero("rst");
    i_rst = 0;
    step();
    chk("idle_busy", o_busy, 0);
    i_enable = 1;
    repeat (3) step();
    sb_en = 1; stab_en = 1; err_chk = 1;
    acc_log.delete();
    frame(1, 0);
    chk("thru_n", acc_log.size(), 8);
    if (acc_log.size() == 8) chk("thru", acc_log[7] - acc_log[0], 7);
    rdy_mode = 2;
    frame(1, 0);
    rdy_mode = 1;
    repeat (4) frame(1, 3);
    rdy_mode = 0;
    nowr = 1;
    for (int i = 0; i < 5; i++) begin push_px(16'($urandom), 0, 0); step(); end
    repeat (12) step();
    chk("sync_drain", rd_ptr, wr_ptr);
    nowr = 0;
    frame(1, 1);
    pulse_sof();
    for (int i = 0; i < 3; i++) begin push_px(16'($urandom), 1, 3'(i)); step(); end
    drain();
    err_chk = 0;
    i_frame_start = 1;
    step();
    chk("err_pulse", o_frame_err, 1);
    chk("err_bank", o_mem_bank, exp_bank);
    i_frame_start = 0;
    step();
    chk("err_once", o_frame_err, 0);
    err_chk = 1;
    frame(0, 0);
    pulse_sof();
    for (int i = 0; i < FW * FH; i++) begin push_px(16'($urandom), 1, 3'(i)); step(); end
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(o_mem_wr && i_mem_ready && o_mem_addr == LAST) && n < 100);
    chk("sim_found", n < 100, 1);
    i_frame_start = 1;
    @(posedge clk);
    #1;
    i_frame_start = 0;
    chk("sim_done", o_frame_done, 1);
    chk("sim_err", o_frame_err, 0);
    exp_bank = !exp_bank;
    chk("sim_bank", o_mem_bank, exp_bank);
    frame(0, 0);
    rdy_mode = 3;
    pulse_sof();
    for (int i = 0; i < 3; i++) begin push_px(16'($urandom), 1, 3'(i)); step(); end
    repeat (6) step();
    chk("stall_held", o_mem_wr, 1);
    sb_en = 0;
    #1 i_rst = 1;
    #1;
    chk_zero("arst");
    exp_q.delete();
    exp_bank = 0;
    step();
    i_rst = 0;
    rdy_mode = 0;
    repeat (6) step();
    sb_en = 1;
    pulse_sof();
    for (int i = 0; i < 3; i++) begin push_px(16'($urandom), 1, 3'(i)); step(); end
    drain();
    i_enable = 0;
    step();
    chk("dis_busy", o_busy, 0);
    chk("dis_wr", o_mem_wr, 0);
    chk("dis_rd", o_obuf_rd, 0);
    nowr = 1;
    rd_before = rd_ptr;
    for (int i = 0; i < 4; i++) begin push_px(16'($urandom), 0, 0); step(); end
    repeat (6) step();
    chk("idle_no_rd", rd_ptr, rd_before);
    i_enable = 1;
    repeat (12) step();
    chk("resync_drain", rd_ptr, wr_ptr);
    nowr = 0;
    frame(1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
